// File: rtl/am_scan_pkg.sv
// Shared types and arithmetic helpers for the AM channel-scan sequencer.
// Helpers work on 64-bit containers, so every width must stay below 64.
package am_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        DWELL,
        COMPARE,
        FINISH
    } scan_state_t;

    localparam int DEF_DEMOD_W   = 60;
    localparam int DEF_MAG_SHIFT = 24;
    localparam int DEF_MAG_W     = 32;
    localparam int DEF_ACC_W     = 48;
    localparam int DEF_CNT_W     = 16;

    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max_val);
        logic [64:0] sum;
        logic [63:0] result;
        sum = {1'b0, a} + {1'b0, b};
        result = (sum > {1'b0, max_val}) ? max_val : sum[63:0];
        return result;
    endfunction

    // The magnitude is taken in 64 bits, so the most negative sample cannot wrap.
    function automatic logic [63:0] abs_shift_sat(input logic [63:0] x,
                                                  input int          shift,
                                                  input logic [63:0] max_val);
        logic [63:0] m;
        m = x[63] ? (~x + 64'd1) : x;
        m = m >> shift;
        return (m > max_val) ? max_val : m;
    endfunction

endpackage

// File: rtl/am_energy_acc.sv
// Demod strobe edge detector and saturating magnitude accumulator for one dwell window.
module am_energy_acc
    import am_scan_pkg::*;
#(
    parameter int DEMOD_W   = DEF_DEMOD_W,
    parameter int MAG_SHIFT = DEF_MAG_SHIFT,
    parameter int MAG_W     = DEF_MAG_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [CNT_W-1:0]   dwell_target,
    input  logic [DEMOD_W-1:0] demod_out,
    input  logic               demod_clk,
    output logic [ACC_W-1:0]   acc,
    output logic               dwell_done
);

    localparam logic [63:0] MAG_MAX = (64'd1 << MAG_W) - 64'd1;
    localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             strobe_q;
    logic [CNT_W-1:0] sample_cnt;
    logic             strobe_edge;
    logic [63:0]      sample_sext;
    logic [63:0]      mag;

    assign strobe_edge = demod_clk & ~strobe_q;
    assign sample_sext = {{(64-DEMOD_W){demod_out[DEMOD_W-1]}}, demod_out};
    assign mag         = abs_shift_sat(sample_sext, MAG_SHIFT, MAG_MAX);
    assign dwell_done  = (sample_cnt == dwell_target);

    // Samples beyond the dwell target are dropped until the FSM leaves DWELL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q   <= 1'b0;
            sample_cnt <= '0;
            acc        <= '0;
        end else begin
            strobe_q <= demod_clk;
            if (clear) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else if (enable && strobe_edge && !dwell_done) begin
                acc        <= ACC_W'(sat_add(64'(acc), mag, ACC_MAX));
                sample_cnt <= sample_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/am_scan_ctrl.sv
// Channel-scan sequencer: steps the LO phase increment across channels, measures
// demod energy at each one and parks the LO on the strongest channel.
module am_scan_ctrl
    import am_scan_pkg::*;
#(
    parameter int DEMOD_W   = DEF_DEMOD_W,
    parameter int MAG_SHIFT = DEF_MAG_SHIFT,
    parameter int MAG_W     = DEF_MAG_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        cfg_phi_start,
    input  logic [31:0]        cfg_phi_step,
    input  logic [CNT_W-1:0]   cfg_num_ch,
    input  logic [CNT_W-1:0]   cfg_settle,
    input  logic [CNT_W-1:0]   cfg_dwell,
    input  logic [DEMOD_W-1:0] demod_out,
    input  logic               demod_clk,
    output logic [31:0]        phi_inc,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   best_idx,
    output logic [ACC_W-1:0]   best_energy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    scan_state_t      state;
    logic [31:0]      phi_step_l;
    logic [31:0]      best_phi;
    logic [CNT_W-1:0] num_ch_l;
    logic [CNT_W-1:0] settle_l;
    logic [CNT_W-1:0] dwell_l;
    logic [CNT_W-1:0] ch;
    logic [CNT_W-1:0] settle_cnt;
    logic [ACC_W-1:0] acc;
    logic             dwell_done;
    logic             acc_clear;
    logic             acc_en;

    assign acc_clear = (state == SETTLE);
    assign acc_en    = (state == DWELL);

    am_energy_acc #(
        .DEMOD_W   (DEMOD_W),
        .MAG_SHIFT (MAG_SHIFT),
        .MAG_W     (MAG_W),
        .ACC_W     (ACC_W),
        .CNT_W     (CNT_W)
    ) u_energy_acc (
        .clk          (clk),
        .rst          (rst),
        .clear        (acc_clear),
        .enable       (acc_en),
        .dwell_target (dwell_l),
        .demod_out    (demod_out),
        .demod_clk    (demod_clk),
        .acc          (acc),
        .dwell_done   (dwell_done)
    );

    // best_phi tracks phi_inc of the best channel so far, which parks the LO without a multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phi_inc     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            best_idx    <= '0;
            best_energy <= '0;
            best_phi    <= '0;
            phi_step_l  <= '0;
            num_ch_l    <= '0;
            settle_l    <= '0;
            dwell_l     <= '0;
            ch          <= '0;
            settle_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                if (state != IDLE) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            phi_step_l  <= cfg_phi_step;
                            num_ch_l    <= (cfg_num_ch == '0) ? CNT_ONE : cfg_num_ch;
                            settle_l    <= cfg_settle;
                            dwell_l     <= (cfg_dwell == '0) ? CNT_ONE : cfg_dwell;
                            phi_inc     <= cfg_phi_start;
                            best_phi    <= cfg_phi_start;
                            best_idx    <= '0;
                            best_energy <= '0;
                            ch          <= '0;
                            settle_cnt  <= '0;
                            busy        <= 1'b1;
                            state       <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt == settle_l) begin
                            state <= DWELL;
                        end else begin
                            settle_cnt <= settle_cnt + CNT_ONE;
                        end
                    end
                    DWELL: begin
                        if (dwell_done) begin
                            state <= COMPARE;
                        end
                    end
                    COMPARE: begin
                        if (acc > best_energy) begin
                            best_energy <= acc;
                            best_idx    <= ch;
                            best_phi    <= phi_inc;
                        end
                        if (ch == num_ch_l - CNT_ONE) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            ch         <= ch + CNT_ONE;
                            phi_inc    <= phi_inc + phi_step_l;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
                    end
                    FINISH: begin
                        phi_inc <= best_phi;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
